rom_read_arbiter: RTL and testbench

Shares the single SDRAM ROM read channel between three read-only caches: the 68k program cache (32-bit), the Z80 sound cache (8-bit) and the tile graphics cache (32-bit). It sits between the caches' `rom_req`/`rom_addr`/`rom_data`/`rom_valid` ports and the SDRAM controller's read port. It grants one request at a time in round-robin order, maps each port's address into its own SDRAM region, and steers the returned word or byte back to the winner.

---
 rtl/rom_read_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_rom_read_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// Purpose : share one SDRAM ROM read channel between the 68k program, Z80 sound and tile caches.
// Latency : grant registered (sdram_req one cycle after an eligible req); data/valid one cycle after sdram_valid.
// Backpressure: a single read is in flight at a time; other requesters wait at their level-held req.
//
// Ports:
//   clk, reset                 : rising-edge clock, synchronous active-high reset
//   pN_req / pN_addr           : level request and address from cache N (p0/p2 word address, p1 byte address)
//   pN_data / pN_valid         : registered read data and one-cycle completion strobe to cache N
//   sdram_req / sdram_addr     : read request (held until sdram_valid) and 4-byte aligned byte address
//   sdram_data / sdram_valid   : returned word and its one-cycle completion strobe
module rom_read_arbiter #(
    parameter logic [24:0] P0_BASE = 25'h000000,
    parameter logic [24:0] P1_BASE = 25'h080000,
    parameter logic [24:0] P2_BASE = 25'h100000
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_req,
    input  logic [18:0] p0_addr,
    output logic [31:0] p0_data,
    output logic        p0_valid,

    input  logic        p1_req,
    input  logic [18:0] p1_addr,
    output logic [7:0]  p1_data,
    output logic        p1_valid,

    input  logic        p2_req,
    input  logic [18:0] p2_addr,
    output logic [31:0] p2_data,
    output logic        p2_valid,

    output logic        sdram_req,
    output logic [24:0] sdram_addr,
    input  logic [31:0] sdram_data,
    input  logic        sdram_valid
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  done_q, done_d;
    logic [2:0]  valid_q, valid_d;
    logic        sdram_req_q, sdram_req_d;
    logic [24:0] sdram_addr_q, sdram_addr_d;
    logic [31:0] p0_data_q, p0_data_d;
    logic [7:0]  p1_data_q, p1_data_d;
    logic [31:0] p2_data_q, p2_data_d;

    logic [2:0]  req_vec;
    logic [3:0]  elig;
    logic [2:0]  done_set;
    logic [1:0]  c0, c1, c2;
    logic        win_vld;
    logic [1:0]  win_port;
    logic [24:0] map0, map1, map2, win_addr;
    logic        gnt_req;
    logic [7:0]  lane_byte;

    // Round-robin successor over ports 0..2; the unused code 3 folds to port 0.
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        logic [1:0] n;
        case (p)
            2'd0:    n = 2'd1;
            2'd1:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    assign req_vec = {p2_req, p1_req, p0_req};

    // Padded to four entries so a 2-bit index never falls outside the vector.
    assign elig = {1'b0, req_vec & ~done_q};

    // Search order begins one past the most recent grant.
    assign c0 = rr_next(last_q);
    assign c1 = rr_next(c0);
    assign c2 = rr_next(c1);

    always_comb begin
        win_vld  = 1'b0;
        win_port = c0;
        if (elig[c0]) begin
            win_vld  = 1'b1;
            win_port = c0;
        end else if (elig[c1]) begin
            win_vld  = 1'b1;
            win_port = c1;
        end else if (elig[c2]) begin
            win_vld  = 1'b1;
            win_port = c2;
        end
    end

    // Byte addresses; sums wrap within the 25-bit SDRAM space.
    assign map0 = P0_BASE + {4'b0000, p0_addr, 2'b00};
    assign map1 = P1_BASE + {6'b000000, p1_addr[18:2], 2'b00};
    assign map2 = P2_BASE + {4'b0000, p2_addr, 2'b00};

    always_comb begin
        win_addr = map0;
        case (win_port)
            2'd1:    win_addr = map1;
            2'd2:    win_addr = map2;
            default: win_addr = map0;
        endcase
    end

    // Whether the port currently holding the grant still wants its data.
    always_comb begin
        gnt_req = 1'b0;
        case (gnt_q)
            2'd0:    gnt_req = p0_req;
            2'd1:    gnt_req = p1_req;
            2'd2:    gnt_req = p2_req;
            default: gnt_req = 1'b0;
        endcase
    end

    // Sound port byte lane; lane 0 is the least significant byte.
    always_comb begin
        lane_byte = sdram_data[7:0];
        case (lane_q)
            2'd1:    lane_byte = sdram_data[15:8];
            2'd2:    lane_byte = sdram_data[23:16];
            2'd3:    lane_byte = sdram_data[31:24];
            default: lane_byte = sdram_data[7:0];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_d       = last_q;
        lane_d       = lane_q;
        sdram_req_d  = sdram_req_q;
        sdram_addr_d = sdram_addr_q;
        p0_data_d    = p0_data_q;
        p1_data_d    = p1_data_q;
        p2_data_d    = p2_data_q;
        valid_d      = 3'b000;
        done_set     = 3'b000;

        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d      = ST_BUSY;
                    gnt_d        = win_port;
                    last_d       = win_port;
                    sdram_req_d  = 1'b1;
                    sdram_addr_d = win_addr;
                    // Lane is captured now; the address may move while the read is in flight.
                    lane_d       = p1_addr[1:0];
                end
            end
            ST_BUSY: begin
                if (sdram_valid) begin
                    state_d     = ST_IDLE;
                    sdram_req_d = 1'b0;
                    // A requester that dropped req has aborted: data is discarded silently.
                    if (gnt_req) begin
                        case (gnt_q)
                            2'd0: begin
                                done_set[0] = 1'b1;
                                valid_d[0]  = 1'b1;
                                p0_data_d   = sdram_data;
                            end
                            2'd1: begin
                                done_set[1] = 1'b1;
                                valid_d[1]  = 1'b1;
                                p1_data_d   = lane_byte;
                            end
                            2'd2: begin
                                done_set[2] = 1'b1;
                                valid_d[2]  = 1'b1;
                                p2_data_d   = sdram_data;
                            end
                            default: begin
                                done_set = 3'b000;
                            end
                        endcase
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                sdram_req_d = 1'b0;
            end
        endcase

        // A finished port stays blocked until its cache lets go of req.
        done_d = req_vec & (done_q | done_set);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 2'd0;
            last_q       <= 2'd2;
            lane_q       <= 2'd0;
            done_q       <= 3'b000;
            valid_q      <= 3'b000;
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= 25'd0;
            p0_data_q    <= 32'd0;
            p1_data_q    <= 8'd0;
            p2_data_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_q       <= last_d;
            lane_q       <= lane_d;
            done_q       <= done_d;
            valid_q      <= valid_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
            p0_data_q    <= p0_data_d;
            p1_data_q    <= p1_data_d;
            p2_data_q    <= p2_data_d;
        end
    end

    assign sdram_req  = sdram_req_q;
    assign sdram_addr = sdram_addr_q;
    assign p0_data    = p0_data_q;
    assign p1_data    = p1_data_q;
    assign p2_data    = p2_data_q;
    assign p0_valid   = valid_q[0];
    assign p1_valid   = valid_q[1];
    assign p2_valid   = valid_q[2];

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: vector table, directed corner sequences, randomized rounds
// checked against a transaction-level model of round-robin order, address map and byte lanes.
module tb_rom_read_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [18:0] addr [3];
    logic [31:0] p0_data, p2_data;
    logic [7:0]  p1_data;
    logic        p0_valid, p1_valid, p2_valid;
    logic        sdram_req;
    logic [24:0] sdram_addr;
    logic [31:0] sdram_data;
    logic        sdram_valid;

    int total = 0;
    int bad   = 0;

    rom_read_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .p0_req      (req[0]),
        .p0_addr     (addr[0]),
        .p0_data     (p0_data),
        .p0_valid    (p0_valid),
        .p1_req      (req[1]),
        .p1_addr     (addr[1]),
        .p1_data     (p1_data),
        .p1_valid    (p1_valid),
        .p2_req      (req[2]),
        .p2_addr     (addr[2]),
        .p2_data     (p2_data),
        .p2_valid    (p2_valid),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_data  (sdram_data),
        .sdram_valid (sdram_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          port;
        logic [18:0] a;
        logic [31:0] rdata;
        logic [24:0] exp_addr;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] exp_data [3];
    int          model_last;

    function automatic logic [2:0] vld();
        return {p2_valid, p1_valid, p0_valid};
    endfunction

    function automatic logic [31:0] get_data(input int p);
        if (p == 0) return p0_data;
        if (p == 1) return {24'd0, p1_data};
        return p2_data;
    endfunction

    // Byte address a cache read should land on, from base + offset arithmetic.
    function automatic logic [24:0] map_addr(input int p, input logic [18:0] a);
        logic [31:0] base, off, sum;
        base = (p == 0) ? 32'h0 : (p == 1) ? 32'h80000 : 32'h100000;
        off  = (p == 1) ? (32'(a) / 4) * 4 : 32'(a) * 4;
        sum  = (base + off) % 32'h2000000;
        return sum[24:0];
    endfunction

    function automatic logic [31:0] port_data(input int p, input logic [18:0] a, input logic [31:0] d);
        if (p == 1) return (d >> (8 * (32'(a) % 4))) & 32'hFF;
        return d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sdram_req(input string name);
        int n;
        n = 0;
        while (sdram_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check(name, {31'd0, sdram_req}, 32'd1);
    endtask

    initial begin
        int g;
        logic [2:0] subset;
        logic [18:0] saddr [3];
        int order [$];
        int p, lat;
        bit abort, abort_early;
        logic [31:0] d;

        vecs[0] = '{0, 19'h00010, 32'hDEADBEEF, 25'h0000040, 32'hDEADBEEF};
        vecs[1] = '{1, 19'h00003, 32'h11223344, 25'h0080000, 32'h00000011};
        vecs[2] = '{1, 19'h00000, 32'h11223344, 25'h0080000, 32'h00000044};
        vecs[3] = '{1, 19'h7FFFE, 32'hAABBCCDD, 25'h00FFFFC, 32'h000000BB};
        vecs[4] = '{2, 19'h7FFFF, 32'h01020304, 25'h02FFFFC, 32'h01020304};
        vecs[5] = '{0, 19'h7FFFF, 32'h89ABCDEF, 25'h01FFFFC, 32'h89ABCDEF};
        vecs[6] = '{1, 19'h00005, 32'hCAFEF00D, 25'h0080004, 32'h000000F0};

        reset = 1'b1;
        req = 3'b000;
        for (int i = 0; i < 3; i++) addr[i] = 19'd0;
        sdram_data = 32'd0;
        sdram_valid = 1'b0;
        repeat (3) step();

        check("reset sdram_req", {31'd0, sdram_req}, 32'd0);
        check("reset sdram_addr", {7'd0, sdram_addr}, 32'd0);
        check("reset valids", {29'd0, vld()}, 32'd0);
        check("reset p0_data", p0_data, 32'd0);
        check("reset p1_data", {24'd0, p1_data}, 32'd0);
        check("reset p2_data", p2_data, 32'd0);
        reset = 1'b0;
        step();
        for (int i = 0; i < 3; i++) exp_data[i] = 32'd0;

        // Vector table: single-port reads through the address map and byte lanes.
        for (int i = 0; i < 7; i++) begin
            p = vecs[i].port;
            req[p] = 1'b1;
            addr[p] = vecs[i].a;
            step();
            check("vec req latency", {31'd0, sdram_req}, 32'd1);
            check("vec sdram_addr", {7'd0, sdram_addr}, {7'd0, vecs[i].exp_addr});
            addr[p] = ~vecs[i].a;
            repeat (2) step();
            sdram_valid = 1'b1;
            sdram_data = vecs[i].rdata;
            step();
            sdram_valid = 1'b0;
            sdram_data = 32'd0;
            check("vec valid", {29'd0, vld()}, 32'd1 << p);
            check("vec data", get_data(p), vecs[i].exp_dat);
            check("vec req dropped", {31'd0, sdram_req}, 32'd0);
            exp_data[p] = vecs[i].exp_dat;
            for (int j = 0; j < 3; j++) begin
                step();
                check("vec no reissue", {28'd0, sdram_req, vld()}, 32'd0);
            end
            req[p] = 1'b0;
            step();
        end

        // Round robin: all three requesting from reset, each re-raised after its strobe.
        for (int i = 0; i < 3; i++) addr[i] = 19'd0;
        req = 3'b111;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_sdram_req("rr request");
            step();
            sdram_valid = 1'b1;
            sdram_data = 32'(i);
            step();
            sdram_valid = 1'b0;
            check("rr grant order", {29'd0, vld()}, 32'd1 << (i % 3));
            g = (vld() == 3'b001) ? 0 : (vld() == 3'b010) ? 1 : (vld() == 3'b100) ? 2 : i % 3;
            check("rr data", get_data(g), 32'(i));
            req[g] = 1'b0;
            if (i == 5) req = 3'b000;
            step();
            if (i < 5) req[g] = 1'b1;
        end
        exp_data[0] = 32'd3;
        exp_data[1] = 32'd4;
        exp_data[2] = 32'd5;
        step();
        check("rr idle after", {31'd0, sdram_req}, 32'd0);

        // Abort: port 2 drops req mid-read while port 1 waits.
        req[2] = 1'b1;
        addr[2] = 19'h00100;
        step();
        check("abort req", {31'd0, sdram_req}, 32'd1);
        check("abort addr", {7'd0, sdram_addr}, 32'h0100400);
        req[1] = 1'b1;
        addr[1] = 19'h00005;
        step();
        req[2] = 1'b0;
        repeat (2) step();
        check("abort req held", {31'd0, sdram_req}, 32'd1);
        sdram_valid = 1'b1;
        sdram_data = 32'h12345678;
        step();
        sdram_valid = 1'b0;
        check("abort no strobe", {29'd0, vld()}, 32'd0);
        check("abort p2_data kept", p2_data, exp_data[2]);
        check("abort req low k+1", {31'd0, sdram_req}, 32'd0);
        step();
        check("abort next grant k+2", {31'd0, sdram_req}, 32'd1);
        check("abort next addr", {7'd0, sdram_addr}, 32'h0080004);
        step();
        sdram_valid = 1'b1;
        sdram_data = 32'hCAFEF00D;
        step();
        sdram_valid = 1'b0;
        check("abort p1 valid", {29'd0, vld()}, 32'd2);
        check("abort p1 data", {24'd0, p1_data}, 32'hF0);
        exp_data[1] = 32'hF0;
        req[1] = 1'b0;
        step();

        // Simultaneous req fall and sdram_valid counts as an abort.
        req[0] = 1'b1;
        addr[0] = 19'h00020;
        step();
        check("simul req", {31'd0, sdram_req}, 32'd1);
        step();
        sdram_valid = 1'b1;
        sdram_data = 32'h00000055;
        req[0] = 1'b0;
        step();
        sdram_valid = 1'b0;
        check("simul no strobe", {29'd0, vld()}, 32'd0);
        check("simul p0_data kept", p0_data, exp_data[0]);
        req[0] = 1'b1;
        step();
        check("simul reissue", {31'd0, sdram_req}, 32'd1);
        sdram_valid = 1'b1;
        sdram_data = 32'h00000066;
        step();
        sdram_valid = 1'b0;
        check("simul reissue valid", {29'd0, vld()}, 32'd1);
        check("simul reissue data", p0_data, 32'h66);
        req[0] = 1'b0;
        step();

        // Reset while busy, then a late sdram_valid.
        req[0] = 1'b1;
        addr[0] = 19'h00001;
        step();
        check("rst busy req", {31'd0, sdram_req}, 32'd1);
        reset = 1'b1;
        req[0] = 1'b0;
        step();
        check("rst drops req", {31'd0, sdram_req}, 32'd0);
        check("rst valids", {29'd0, vld()}, 32'd0);
        reset = 1'b0;
        sdram_valid = 1'b1;
        sdram_data = 32'hFFFFFFFF;
        step();
        sdram_valid = 1'b0;
        check("late valid no strobe", {28'd0, sdram_req, vld()}, 32'd0);
        check("late valid p0_data", p0_data, 32'd0);
        step();
        check("late valid no req", {31'd0, sdram_req}, 32'd0);
        for (int i = 0; i < 3; i++) exp_data[i] = 32'd0;
        model_last = 2;

        // Randomized rounds against the transaction-level model.
        for (int r = 0; r < 40; r++) begin
            subset = 3'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++) begin
                if (subset[i]) begin
                    addr[i] = 19'($urandom);
                    saddr[i] = addr[i];
                    req[i] = 1'b1;
                end
            end
            order.delete();
            for (int i = 1; i <= 3; i++) begin
                if (subset[(model_last + i) % 3]) order.push_back((model_last + i) % 3);
            end
            foreach (order[k]) begin
                p = order[k];
                wait_sdram_req("rand request");
                check("rand addr", {7'd0, sdram_addr}, {7'd0, map_addr(p, saddr[p])});
                addr[p] = 19'($urandom);
                lat = $urandom_range(0, 4);
                abort = ($urandom_range(0, 5) == 0);
                abort_early = abort && ($urandom_range(0, 1) == 1);
                d = $urandom;
                if (abort_early) req[p] = 1'b0;
                repeat (lat) step();
                sdram_valid = 1'b1;
                sdram_data = d;
                if (abort) req[p] = 1'b0;
                step();
                sdram_valid = 1'b0;
                if (!abort) exp_data[p] = port_data(p, saddr[p], d);
                check("rand strobe", {29'd0, vld()}, abort ? 32'd0 : (32'd1 << p));
                check("rand data", get_data(p), exp_data[p]);
                check("rand req low", {31'd0, sdram_req}, 32'd0);
                model_last = p;
                req[p] = 1'b0;
            end
            step();
            check("rand round idle", {31'd0, sdram_req}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
